// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx                                                         |
// | Purpose  : 8N1 UART receiver with valid/ready output and error pulses      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       UART_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int c_CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_START = 3'd1;
   localparam logic [2:0] c_DATA  = 3'd2;
   localparam logic [2:0] c_STOP  = 3'd3;
   localparam logic [2:0] c_BREAK = 3'd4;

   logic               r_sync_meta;
   logic               rx_sync;
   logic [2:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_done;
   logic               w_bit_end;

   assign w_bit_end = (r_cnt == c_BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_meta <= 1'b1;
         rx_sync     <= 1'b1;
      end else begin
         r_sync_meta <= UART_rx;
         rx_sync     <= r_sync_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_done    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         frame_err <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (!rx_sync) begin
                  r_state <= c_START;
                  r_cnt   <= '0;
               end
            end
            c_START: begin
               // Mid-start-bit recheck rejects short glitches as false starts.
               if (r_cnt == c_HALF_LAST) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= rx_sync ? c_IDLE : c_DATA;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            c_DATA: begin
               if (w_bit_end) begin
                  r_cnt              <= '0;
                  r_shift[r_bit_idx] <= rx_sync;
                  r_bit_idx          <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= c_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            c_STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (rx_sync) begin
                     r_done  <= 1'b1;
                     r_state <= c_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     r_state   <= c_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            c_BREAK: begin
               if (rx_sync) begin
                  r_state <= c_IDLE;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // A completed byte always wins over a same-cycle handshake; it only counts
   // as an overrun when the pending byte was not being taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (r_done) begin
            rx_data  <= r_shift;
            rx_valid <= 1'b1;
            overrun  <= rx_valid & ~rx_ready;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
